writeback_unit: RTL and testbench
=================================

# writeback_unit

Write-back stage that drives the write port (LE, RW, PW) of the 32x32 register file. It accepts results from the ALU path and the load path, aligns and extends load data, and serialises simultaneous results through a small FIFO so that at most one register write commits per cycle. It also keeps a per-register pending-write scoreboard that decode uses to detect read-after-write hazards on the three read ports.

## Interface
- FIFO_DEPTH, 4: deferred-write FIFO entries (power of two, >= 2)
- CNT_W, 3: width of each per-register pending counter
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load result present this cycle
- mem_rd  in  5  load destination register
- mem_data  in  32  raw word read from data memory
- mem_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and treated as word
- mem_signed  in  1  1 = sign-extend, 0 = zero-extend
- mem_off  in  2  byte offset of the access within the word
- iss_valid  in  1  an instruction writing iss_rd is issued this cycle
- iss_rd  in  5  destination register of the issued instruction
- iss_ready  out  1  issue accepted; low when pend[iss_rd] is saturated
- qa, qb, qd  in  5 each  register numbers currently read on ports A, B, D
- busy_a, busy_b, busy_d  out  1 each  the queried register has a pending write
- wb_stall  out  1  producers must hold their results
- misalign_err  out  1  one-cycle pulse when a load is misaligned
- LE  out  1  register-file write enable
- RW  out  5  register-file write address
- PW  out  32  register-file write data

## Operation
- Load alignment is combinational on the load inputs:
  - Byte: the lane is mem_data[8*off+7 : 8*off].
  - Halfword: the lane is mem_data[16*off[1]+15 : 16*off[1]]. It is misaligned when off[0] = 1.
  - Word: misaligned when off != 0.
  - The selected lane is sign- or zero-extended according to mem_signed.
- Misaligned load:
  - No write is issued.
  - misalign_err pulses high for one cycle.
  - pend[mem_rd] is decremented so the scoreboard stays consistent.
- Results with rd = 0 are discarded: no write and no FIFO entry. The scoreboard is never incremented for register 0.
- Valid inputs are ignored while wb_stall = 1. Producers hold their results until wb_stall drops.
- Selection at each rising edge, in priority order:
  - If the FIFO is non-empty: the write register loads the FIFO head, which is popped. Incoming results are pushed, load first, then ALU.
  - Else, if both sources are valid: the write register loads the load result and the ALU result is pushed.
  - Else, if one source is valid: the write register loads it.
  - Else: LE <= 0. RW and PW hold their previous values.
- wb_stall = (fifo_count >= FIFO_DEPTH-1), computed from registered state. This guarantees room for two pushes.
- Scoreboard, per register, as a CNT_W-bit counter:
  - Increment on an accepted issue (iss_valid & iss_ready, iss_rd != 0).
  - Decrement at an edge where LE = 1 for that RW, or on a misalignment drop.
  - Increment and decrement on the same register in the same cycle leave the count unchanged.
  - iss_ready = (pend[iss_rd] != 2^CNT_W - 1).
- busy_x = (qx != 0) & (pend[qx] != 0). This is combinational from registered counters.

## Timing
- Reset values: LE = 0, RW = 0, PW = 0, misalign_err = 0, wb_stall = 0, FIFO empty, all counters 0. Consequently iss_ready = 1 and all busy outputs are 0.
- A non-conflicting result at cycle N gives LE = 1 in cycle N+1, and the register file updates at the end of N+1.
- A result deferred through the FIFO appears k cycles later, where k is its FIFO position + 1.
- Back-to-back writes every cycle are supported.
- misalign_err is asserted in cycle N+1 for a misaligned load at cycle N.
- busy clears in the cycle after the committing LE edge. This is conservative; the register file's internal forwarding covers same-cycle reads.
- Reset during operation flushes the FIFO and scoreboard and drops any pending write. No LE is asserted in the cycle after reset.

## Test plan
- After reset, alu_valid = 1, rd = 5, data = 0x1234_5678: the next cycle shows LE = 1, RW = 5, PW = 0x1234_5678. The cycle after that shows LE = 0.
- Both sources valid in the same cycle, load rd = 3 with word 0xDEAD_BEEF, ALU rd = 4 with 0x11: LE cycles show {3, 0xDEAD_BEEF} then {4, 0x11}. fifo_count peaks at 1.
- Load mem_data = 0x80FF_7F01:
  - byte, off = 3, signed gives PW = 0xFFFF_FF80.
  - half, off = 2, unsigned gives PW = 0x0000_80FF.
  - half, off = 1 gives no LE and misalign_err = 1.
- Issue rd = 7 twice, then query qa = 7: busy_a stays 1 after the first commit and drops after the second commit. Issues on rd = 7 until the counter saturates drive iss_ready = 0.
- Both sources valid every cycle: wb_stall rises when fifo_count reaches 3, all writes commit in order, and none is lost. ALU rd = 0 produces no LE.
- Reset asserted while the FIFO holds 2 entries: the next cycle shows LE = 0, wb_stall = 0, and all busy outputs = 0.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: commits ALU and load results to the register file write port, one write per cycle.
// Latency: 1 cycle from an accepted result to LE when the FIFO is empty; deferred results follow in arrival order.
// Backpressure: wb_stall is high while the FIFO holds >= FIFO_DEPTH-1 entries; producers hold and valids are ignored.
//
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data    ALU result
//   mem_valid/mem_rd/mem_data    raw load word, with mem_size/mem_signed/mem_off selecting the lane
//   iss_valid/iss_rd/iss_ready   issue handshake that bumps the pending-write counter of iss_rd
//   qa/qb/qd -> busy_a/b/d       hazard query for the three read ports
//   wb_stall, misalign_err       producer hold, one-cycle misaligned-load pulse
//   LE/RW/PW                     register-file write port
module writeback_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [1:0]  mem_off,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  qa,
  input  logic [4:0]  qb,
  input  logic [4:0]  qd,
  output logic        busy_a,
  output logic        busy_b,
  output logic        busy_d,
  output logic        wb_stall,
  output logic        misalign_err,
  output logic        LE,
  output logic [4:0]  RW,
  output logic [31:0] PW
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_F = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  // ---------------------------------------------------------------------------
  // Load lane selection and extension
  // ---------------------------------------------------------------------------
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic        load_mis;

  always_comb begin
    case (mem_off)
      2'd0:    lane_b = mem_data[7:0];
      2'd1:    lane_b = mem_data[15:8];
      2'd2:    lane_b = mem_data[23:16];
      default: lane_b = mem_data[31:24];
    endcase
    lane_h = mem_off[1] ? mem_data[31:16] : mem_data[15:0];

    // Word access (size 10, and the illegal 11 encoding) is the fallthrough.
    load_val = mem_data;
    load_mis = (mem_off != 2'd0);
    if (mem_size == 2'b00) begin
      load_val = {{24{mem_signed & lane_b[7]}}, lane_b};
      load_mis = 1'b0;
    end else if (mem_size == 2'b01) begin
      load_val = {{16{mem_signed & lane_h[15]}}, lane_h};
      load_mis = mem_off[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Input acceptance
  // ---------------------------------------------------------------------------
  logic    mem_acc;
  logic    mis_drop;
  logic    mem_ok;
  logic    alu_ok;
  wb_ent_t mem_ent;
  wb_ent_t alu_ent;

  assign mem_acc  = mem_valid & ~wb_stall;
  assign mis_drop = mem_acc & load_mis;
  // Register 0 results are discarded outright: they never occupy a slot.
  assign mem_ok   = mem_acc & ~load_mis & (mem_rd != 5'd0);
  assign alu_ok   = alu_valid & ~wb_stall & (alu_rd != 5'd0);
  assign mem_ent  = {mem_rd, load_val};
  assign alu_ent  = {alu_rd, alu_data};

  // ---------------------------------------------------------------------------
  // Deferred-write FIFO (up to two pushes and one pop per cycle)
  // ---------------------------------------------------------------------------
  wb_ent_t          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_F-1:0] fifo_count;
  wb_ent_t          fifo_head;
  logic             fifo_nonempty;

  assign fifo_head     = fifo_mem[rd_ptr];
  assign fifo_nonempty = (fifo_count != '0);
  // Stalling one entry early leaves room for a same-cycle double push.
  assign wb_stall      = (fifo_count >= CNT_F'(FIFO_DEPTH - 1));

  logic       wr_load;
  wb_ent_t    wr_ent;
  logic       pop;
  logic [1:0] n_push;
  wb_ent_t    push0;
  wb_ent_t    push1;

  // Older entries always drain first; within a cycle the load precedes the ALU.
  always_comb begin
    wr_load = 1'b0;
    wr_ent  = '0;
    pop     = 1'b0;
    n_push  = 2'd0;
    push0   = '0;
    push1   = '0;
    if (fifo_nonempty) begin
      wr_load = 1'b1;
      wr_ent  = fifo_head;
      pop     = 1'b1;
      if (mem_ok && alu_ok) begin
        n_push = 2'd2;
        push0  = mem_ent;
        push1  = alu_ent;
      end else if (mem_ok) begin
        n_push = 2'd1;
        push0  = mem_ent;
      end else if (alu_ok) begin
        n_push = 2'd1;
        push0  = alu_ent;
      end
    end else if (mem_ok && alu_ok) begin
      wr_load = 1'b1;
      wr_ent  = mem_ent;
      n_push  = 2'd1;
      push0   = alu_ent;
    end else if (mem_ok) begin
      wr_load = 1'b1;
      wr_ent  = mem_ent;
    end else if (alu_ok) begin
      wr_load = 1'b1;
      wr_ent  = alu_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_count   <= '0;
      LE           <= 1'b0;
      RW           <= 5'd0;
      PW           <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr + PTR_W'(pop);
      wr_ptr       <= wr_ptr + PTR_W'(n_push);
      fifo_count   <= fifo_count + CNT_F'(n_push) - CNT_F'(pop);
      misalign_err <= mis_drop;
      LE           <= wr_load;
      // RW/PW hold their last value on idle cycles.
      if (wr_load) begin
        RW <= wr_ent.rd;
        PW <= wr_ent.data;
      end
    end
  end

  // Payload storage needs no reset: the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (n_push != 2'd0) fifo_mem[wr_ptr] <= push0;
      if (n_push == 2'd2) fifo_mem[wr_ptr + PTR_W'(1)] <= push1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pend [32];
  logic             iss_acc;
  logic [31:0]      inc_hit;
  logic [31:0]      com_hit;
  logic [31:0]      drop_hit;

  assign iss_ready = (pend[iss_rd] != {CNT_W{1'b1}});
  assign iss_acc   = iss_valid & iss_ready & (iss_rd != 5'd0);

  // A commit (the LE currently on the port) and a misalignment drop can hit
  // the same register in one cycle, so the decrement can be two.
  always_comb begin
    inc_hit  = '0;
    com_hit  = '0;
    drop_hit = '0;
    if (iss_acc)  inc_hit[iss_rd]  = 1'b1;
    if (LE)       com_hit[RW]      = 1'b1;
    if (mis_drop) drop_hit[mem_rd] = 1'b1;
  end

  // Decrements floor at zero so a result with no matching issue cannot wrap
  // a counter into a permanent false hazard; register 0 therefore stays 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        case ({inc_hit[i], com_hit[i], drop_hit[i]})
          3'b100:                 pend[i] <= pend[i] + CNT_W'(1);
          3'b010, 3'b001, 3'b111: pend[i] <= (pend[i] == '0) ? '0 : pend[i] - CNT_W'(1);
          3'b011:                 pend[i] <= (pend[i] <= CNT_W'(1)) ? '0 : pend[i] - CNT_W'(2);
          default:                pend[i] <= pend[i];
        endcase
      end
    end
  end

  assign busy_a = (qa != 5'd0) & (pend[qa] != '0);
  assign busy_b = (qb != 5'd0) & (pend[qb] != '0);
  assign busy_d = (qd != 5'd0) & (pend[qd] != '0);

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed steps followed by randomized traffic.
// The reference keeps all accepted results as one ordered queue that drains
// one entry per cycle, and the scoreboard as plain integer counts per register.
module tb_writeback_unit;
  localparam int DEPTH = 4;
  localparam int CMAX  = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [1:0]  mem_off;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  qa, qb, qd;
  logic        busy_a, busy_b, busy_d;
  logic        wb_stall;
  logic        misalign_err;
  logic        LE;
  logic [4:0]  RW;
  logic [31:0] PW;

  writeback_unit #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_size(mem_size), .mem_signed(mem_signed), .mem_off(mem_off),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .qa(qa), .qb(qb), .qd(qd),
    .busy_a(busy_a), .busy_b(busy_b), .busy_d(busy_d),
    .wb_stall(wb_stall), .misalign_err(misalign_err),
    .LE(LE), .RW(RW), .PW(PW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  outstanding[$];
  int          pend_m[32];
  logic        m_le  = 1'b0;
  logic [4:0]  m_rw  = 5'd0;
  logic [31:0] m_pw  = 32'd0;
  logic        m_mis = 1'b0;
  int          errors = 0;
  int          checks = 0;
  bit          stall_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit misaligned_m(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'b00) return 1'b0;
    if (size == 2'b01) return off[0];
    return off != 2'd0;
  endfunction

  function automatic logic [31:0] load_m(input logic [31:0] w, input logic [1:0] size,
                                         input bit sgn, input logic [1:0] off);
    longint v;
    int     bits;
    if (size == 2'b00) begin
      bits = 8;
      v = (w >> (8 * off)) & 32'hFF;
    end else if (size == 2'b01) begin
      bits = 16;
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
    end else begin
      bits = 32;
      v = w;
    end
    if (sgn && bits < 32 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // Advance the reference by one clock edge using the inputs as currently driven.
  task automatic model_step();
    int   d[32];
    bit   stall;
    ent_t ne;
    if (reset) begin
      mq.delete();
      foreach (pend_m[i]) pend_m[i] = 0;
      m_le = 1'b0; m_rw = 5'd0; m_pw = 32'd0; m_mis = 1'b0;
      return;
    end
    foreach (d[i]) d[i] = 0;
    stall = (mq.size() >= DEPTH - 1);
    if (iss_valid && iss_rd != 5'd0 && pend_m[iss_rd] != CMAX) d[iss_rd]++;
    if (m_le) d[m_rw]--;
    m_mis = 1'b0;
    if (!stall && mem_valid) begin
      if (misaligned_m(mem_size, mem_off)) begin
        m_mis = 1'b1;
        d[mem_rd]--;
      end else if (mem_rd != 5'd0) begin
        ne.rd = mem_rd;
        ne.data = load_m(mem_data, mem_size, mem_signed, mem_off);
        mq.push_back(ne);
      end
    end
    if (!stall && alu_valid && alu_rd != 5'd0) begin
      ne.rd = alu_rd;
      ne.data = alu_data;
      mq.push_back(ne);
    end
    if (mq.size() > 0) begin
      ne = mq.pop_front();
      m_le = 1'b1; m_rw = ne.rd; m_pw = ne.data;
    end else begin
      m_le = 1'b0;
    end
    for (int i = 1; i < 32; i++) begin
      pend_m[i] += d[i];
      if (pend_m[i] < 0) pend_m[i] = 0;
    end
  endtask

  // Check combinational outputs, clock once, then check registered outputs.
  task automatic tick(input string tag);
    #1;
    check({tag, ":iss_ready"}, iss_ready, pend_m[iss_rd] != CMAX);
    check({tag, ":busy_a"}, busy_a, qa != 5'd0 && pend_m[qa] != 0);
    check({tag, ":busy_b"}, busy_b, qb != 5'd0 && pend_m[qb] != 0);
    check({tag, ":busy_d"}, busy_d, qd != 5'd0 && pend_m[qd] != 0);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ":LE"}, LE, m_le);
    check({tag, ":RW"}, RW, m_rw);
    check({tag, ":PW"}, PW, m_pw);
    check({tag, ":misalign"}, misalign_err, m_mis);
    check({tag, ":wb_stall"}, wb_stall, mq.size() >= DEPTH - 1);
    if (wb_stall === 1'b1) stall_seen = 1'b1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    iss_valid = 1'b0;
  endtask

  function automatic logic [4:0] take_rd();
    if ($urandom_range(9) == 0) return 5'd0;
    if (outstanding.size() > 0) return outstanding.pop_front();
    return 5'd0;
  endfunction

  task automatic rand_cycle(input int p_mem, input int p_alu, input int p_iss);
    bit acc;
    iss_valid = ($urandom_range(99) < p_iss);
    iss_rd = 5'($urandom_range(31));
    qa = 5'($urandom_range(31));
    qb = 5'($urandom_range(31));
    qd = 5'($urandom_range(31));
    // Producers only present new results when not stalled; otherwise they hold.
    if (mq.size() < DEPTH - 1) begin
      mem_valid  = ($urandom_range(99) < p_mem);
      mem_rd     = mem_valid ? take_rd() : 5'd0;
      mem_data   = $urandom();
      mem_size   = 2'($urandom_range(3));
      mem_signed = 1'($urandom_range(1));
      mem_off    = 2'($urandom_range(3));
      alu_valid  = ($urandom_range(99) < p_alu);
      alu_rd     = alu_valid ? take_rd() : 5'd0;
      alu_data   = $urandom();
    end
    acc = iss_valid && iss_rd != 5'd0 && pend_m[iss_rd] != CMAX;
    tick("rnd");
    if (acc) outstanding.push_back(iss_rd);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    alu_rd = 5'd0; alu_data = 32'd0;
    mem_rd = 5'd0; mem_data = 32'd0; mem_size = 2'b10; mem_signed = 1'b0; mem_off = 2'd0;
    iss_rd = 5'd7;
    qa = 5'd5; qb = 5'd6; qd = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    check("rst_LE", LE, 1'b0);
    check("rst_RW", RW, 5'd0);
    check("rst_PW", PW, 32'd0);
    check("rst_misalign", misalign_err, 1'b0);
    check("rst_stall", wb_stall, 1'b0);
    check("rst_iss_ready", iss_ready, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_busy_d", busy_d, 1'b0);
    reset = 1'b0;

    // Single ALU result.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick("alu1");
    check("alu1_LE", LE, 1'b1);
    check("alu1_RW", RW, 5'd5);
    check("alu1_PW", PW, 32'h1234_5678);
    idle_inputs();
    tick("alu1_after");
    check("alu1_LE_off", LE, 1'b0);

    // Load and ALU in the same cycle.
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick("both_iss");
    iss_rd = 5'd4;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hDEAD_BEEF; mem_size = 2'b10; mem_signed = 1'b0; mem_off = 2'd0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h11;
    tick("both0");
    check("both0_RW", RW, 5'd3);
    check("both0_PW", PW, 32'hDEAD_BEEF);
    idle_inputs();
    tick("both1");
    check("both1_LE", LE, 1'b1);
    check("both1_RW", RW, 5'd4);
    check("both1_PW", PW, 32'h11);
    tick("both2");
    check("both2_LE", LE, 1'b0);

    // Load alignment on 0x80FF_7F01.
    mem_data = 32'h80FF_7F01;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_size = 2'b00; mem_signed = 1'b1; mem_off = 2'd3;
    iss_valid = 1'b1; iss_rd = 5'd10;
    tick("ld_b3s");
    check("ld_b3s_PW", PW, 32'hFFFF_FF80);
    mem_rd = 5'd11; mem_size = 2'b01; mem_signed = 1'b0; mem_off = 2'd2; iss_rd = 5'd11;
    tick("ld_h2u");
    check("ld_h2u_PW", PW, 32'h0000_80FF);
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick("ld_iss9");
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_size = 2'b01; mem_signed = 1'b1; mem_off = 2'd1;
    qa = 5'd9;
    #1;
    check("mis_busy_pre", busy_a, 1'b1);
    tick("ld_h1");
    check("mis_LE", LE, 1'b0);
    check("mis_pulse", misalign_err, 1'b1);
    idle_inputs();
    #1;
    check("mis_busy_post", busy_a, 1'b0);
    tick("ld_h1_after");
    check("mis_pulse_end", misalign_err, 1'b0);

    // Scoreboard: two issues on r7, two commits.
    iss_valid = 1'b1; iss_rd = 5'd7; qa = 5'd7;
    tick("sb_iss1");
    tick("sb_iss2");
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA5A5_0007;
    tick("sb_w1");
    idle_inputs();
    tick("sb_c1");
    #1;
    check("sb_busy_after_first", busy_a, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h5A5A_0007;
    tick("sb_w2");
    idle_inputs();
    tick("sb_c2");
    #1;
    check("sb_busy_after_second", busy_a, 1'b0);

    // ALU result to r0 is discarded.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    tick("r0");
    check("r0_LE", LE, 1'b0);
    idle_inputs();

    // Saturate pend[7].
    iss_valid = 1'b1; iss_rd = 5'd7;
    repeat (7) tick("sat");
    #1;
    check("sat_iss_ready", iss_ready, 1'b0);
    tick("sat_extra");
    check("sat_iss_ready_hold", iss_ready, 1'b0);

    // Reset while the FIFO holds two entries.
    for (int r = 12; r <= 15; r++) begin
      iss_valid = 1'b1; iss_rd = 5'(r);
      tick("rf_iss");
    end
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd12; mem_size = 2'b10; mem_off = 2'd0; mem_data = 32'hC0DE_0012;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h13;
    tick("rf_push1");
    mem_rd = 5'd14; mem_data = 32'hC0DE_0014;
    alu_rd = 5'd15; alu_data = 32'h15;
    tick("rf_push2");
    reset = 1'b1;
    qa = 5'd14; qb = 5'd7; qd = 5'd15; iss_rd = 5'd7;
    tick("rf_reset");
    check("rf_LE", LE, 1'b0);
    check("rf_stall", wb_stall, 1'b0);
    check("rf_busy_a", busy_a, 1'b0);
    check("rf_busy_b", busy_b, 1'b0);
    check("rf_busy_d", busy_d, 1'b0);
    reset = 1'b0;
    idle_inputs();
    tick("rf_post1");
    check("rf_post1_LE", LE, 1'b0);
    tick("rf_post2");
    check("rf_post2_LE", LE, 1'b0);

    // Randomized traffic: build up outstanding issues, then saturate both sources.
    for (int i = 0; i < 30; i++) rand_cycle(0, 0, 100);
    stall_seen = 1'b0;
    for (int i = 0; i < 16; i++) rand_cycle(100, 100, 50);
    check("stall_rose", stall_seen, 1'b1);
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        reset = 1'b1;
        idle_inputs();
        tick("rnd_reset");
        reset = 1'b0;
        outstanding.delete();
      end
      rand_cycle(50, 50, 60);
    end
    idle_inputs();
    repeat (8) tick("drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
